// File: rtl/robs_microseq.sv
`default_nettype none
// ============================================================================
// Module   : robs_microseq
// Purpose  : Microprogram sequencer. Drives uaddr into a combinational control
//            store and decodes the returned microinstruction into next-address
//            and control outputs. Define ROBS_USTACK_EN to build the CALL/RET
//            return stack.
// Revision : 1.0 - initial release
// ============================================================================
module robs_microseq #(
  parameter  int UPC_W       = 5,
  parameter  int CTRL_W      = 15,
  parameter  int NCOND       = 3,
  parameter  int STACK_DEPTH = 4,
  localparam int CSEL_W      = $clog2(NCOND + 2),
  localparam int UI_W        = CTRL_W + UPC_W + CSEL_W + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NCOND-1:0]  cond,
  input  logic [UI_W-1:0]   uinstr,
  output logic [UPC_W-1:0]  uaddr,
  output logic [CTRL_W-1:0] c,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [2:0] c_OP_CJMP = 3'b000;
  localparam logic [2:0] c_OP_LDC  = 3'b001;
  localparam logic [2:0] c_OP_DJNZ = 3'b010;
  localparam logic [2:0] c_OP_CALL = 3'b011;
  localparam logic [2:0] c_OP_RET  = 3'b100;
  localparam logic [2:0] c_OP_HALT = 3'b101;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_done;
  logic [UPC_W-1:0]  r_upc;
  logic [UPC_W-1:0]  w_upc_nxt;
  logic [UPC_W-1:0]  w_upc_inc;
  logic [UPC_W-1:0]  r_cnt;
  logic [UPC_W-1:0]  w_cnt_nxt;
  logic [CTRL_W-1:0] w_ctrl;
  logic [UPC_W-1:0]  w_target;
  logic [CSEL_W-1:0] w_csel;
  logic [2:0]        w_op;
  logic              w_cond_true;
  logic              w_launch;

  assign w_ctrl    = uinstr[CTRL_W-1:0];
  assign w_target  = uinstr[CTRL_W +: UPC_W];
  assign w_csel    = uinstr[CTRL_W+UPC_W +: CSEL_W];
  assign w_op      = uinstr[UI_W-1 -: 3];
  assign w_upc_inc = r_upc + UPC_W'(1);
  assign w_launch  = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

  assign uaddr = r_upc;
  assign done  = r_done;

  // Condition select: 0 and unused codes are false, all-ones is always true.
  always_comb begin
    w_cond_true = 1'b0;
    if (w_csel == {CSEL_W{1'b1}}) begin
      w_cond_true = 1'b1;
    end else begin
      for (int i = 0; i < NCOND; i++) begin
        if (w_csel == CSEL_W'(i + 1)) w_cond_true = cond[i];
      end
    end
  end

`ifdef ROBS_USTACK_EN
  localparam int c_SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int c_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [UPC_W-1:0]  r_stack [STACK_DEPTH];
  logic [c_SP_W-1:0] r_sp;
  logic              r_err;
  logic              w_push;
  logic              w_pop;
  logic              w_err_set;
  logic              w_full;
  logic              w_empty;
  logic [UPC_W-1:0]  w_top;

  assign w_full  = (r_sp == c_SP_W'(STACK_DEPTH));
  assign w_empty = (r_sp == '0);
  assign w_top   = r_stack[c_IDX_W'(r_sp - c_SP_W'(1))];
  assign err     = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_launch)    r_sp <= '0;
      else if (w_push) r_sp <= r_sp + c_SP_W'(1);
      else if (w_pop)  r_sp <= r_sp - c_SP_W'(1);
      if (w_err_set)   r_err <= 1'b1;
    end
  end

  // Stack contents survive restarts; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[c_IDX_W'(r_sp)] <= w_upc_inc;
  end
`else
  assign err = 1'b0;
`endif

  // Next micro-PC and loop counter.
  always_comb begin
    w_upc_nxt = r_upc;
    w_cnt_nxt = r_cnt;
`ifdef ROBS_USTACK_EN
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
`endif
    if (w_launch) begin
      w_upc_nxt = '0;
    end else if (r_state == c_ST_RUN) begin
      case (w_op)
        c_OP_CJMP: w_upc_nxt = w_cond_true ? w_target : w_upc_inc;
        c_OP_LDC: begin
          w_cnt_nxt = w_target;
          w_upc_nxt = w_upc_inc;
        end
        c_OP_DJNZ: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - UPC_W'(1);
            w_upc_nxt = w_target;
          end else begin
            w_upc_nxt = w_upc_inc;
          end
        end
`ifdef ROBS_USTACK_EN
        c_OP_CALL: begin
          w_upc_nxt = w_upc_inc;
          if (w_cond_true) begin
            if (w_full) begin
              w_err_set = 1'b1;
            end else begin
              w_push    = 1'b1;
              w_upc_nxt = w_target;
            end
          end
        end
        c_OP_RET: begin
          if (w_empty) begin
            w_err_set = 1'b1;
            w_upc_nxt = w_upc_inc;
          end else begin
            w_pop     = 1'b1;
            w_upc_nxt = w_top;
          end
        end
`endif
        c_OP_HALT: w_upc_nxt = r_upc;
        default:   w_upc_nxt = w_upc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_upc <= '0;
      r_cnt <= '0;
    end else begin
      r_upc <= w_upc_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == c_ST_DONE);
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_DONE: if (start) w_state_nxt = c_ST_RUN;
      c_ST_RUN:             if (w_op == c_OP_HALT) w_state_nxt = c_ST_DONE;
      default:              w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    c    = '0;
    if (r_state == c_ST_RUN) begin
      busy = 1'b1;
      c    = w_ctrl;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_robs_microseq.sv
`default_nettype none
// Testbench for robs_microseq: per-cycle scoreboard fed by an
// instruction-level reference model of the microprogram.
module tb_robs_microseq;

  localparam int UPC_W       = 5;
  localparam int CTRL_W      = 15;
  localparam int NCOND       = 3;
  localparam int STACK_DEPTH = 4;
  localparam int CSEL_W      = 3;
  localparam int UI_W        = CTRL_W + UPC_W + CSEL_W + 3;
  localparam int DEPTH       = 32;
  localparam int MAXS        = 300;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [NCOND-1:0]  cond  = '0;
  logic [UI_W-1:0]   uinstr;
  logic [UPC_W-1:0]  uaddr;
  logic [CTRL_W-1:0] c;
  logic              busy;
  logic              done;
  logic              err;

  logic [UI_W-1:0]  mem      [DEPTH];
  logic [NCOND-1:0] cond_seq [MAXS];

  robs_microseq #(
    .UPC_W(UPC_W), .CTRL_W(CTRL_W), .NCOND(NCOND), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cond(cond), .uinstr(uinstr),
    .uaddr(uaddr), .c(c), .busy(busy), .done(done), .err(err)
  );

  assign uinstr = mem[uaddr];
  always #5 clk = ~clk;

  typedef struct { int ua; int cw; int e; } rec_t;
  rec_t exp_q[$];
  rec_t halt_q[$];
  rec_t mon_r;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   m_cnt   = 0;
  int   m_err   = 0;
  int   done_cyc = 0;
  int   c1_cnt  = 0;
  int   last_halt = 0;
  bit   mon_en  = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [UI_W-1:0] mk(input int op, input int cs, input int tg, input int cw);
    return {3'(op), CSEL_W'(cs), UPC_W'(tg), CTRL_W'(cw)};
  endfunction

  function automatic bit cond_eval(input int cs, input logic [NCOND-1:0] cv);
    if (cs == (1 << CSEL_W) - 1) return 1'b1;
    if (cs >= 1 && cs <= NCOND) return cv[cs-1];
    return 1'b0;
  endfunction

  // Executes the program in mem one instruction at a time.
  task automatic model(input bit commit, output int len, output bit ok);
    int upc, cnt, e, op, cs, tg, cw, nxt;
    bit t;
    int stk[$];
    logic [UI_W-1:0] ins;
    upc = 0; cnt = m_cnt; e = m_err; len = 0; ok = 1'b0;
    for (int s = 0; s < MAXS; s++) begin
      ins = mem[upc];
      op  = int'(ins[UI_W-1 -: 3]);
      cs  = int'(ins[CTRL_W+UPC_W +: CSEL_W]);
      tg  = int'(ins[CTRL_W +: UPC_W]);
      cw  = int'(ins[CTRL_W-1:0]);
      if (commit) exp_q.push_back('{upc, cw, e});
      t   = cond_eval(cs, cond_seq[s]);
      nxt = (upc + 1) % DEPTH;
      if (op == 5) begin
        len = s + 1;
        ok  = 1'b1;
        if (commit) begin
          halt_q.push_back('{upc, 0, e});
          m_cnt = cnt;
          m_err = e;
        end
        return;
      end
      case (op)
        0: upc = t ? tg : nxt;
        1: begin cnt = tg; upc = nxt; end
        2: if (cnt != 0) begin cnt--; upc = tg; end else upc = nxt;
`ifdef ROBS_USTACK_EN
        3: begin
          if (!t) upc = nxt;
          else if (stk.size() == STACK_DEPTH) begin e = 1; upc = nxt; end
          else begin stk.push_back(nxt); upc = tg; end
        end
        4: if (stk.size() == 0) begin e = 1; upc = nxt; end else upc = stk.pop_back();
`endif
        default: upc = nxt;
      endcase
    end
  endtask

  // Monitor: compares every RUN cycle and every done rise against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      prev_done = 1'b0;
    end else if (mon_en) begin
      if (busy) begin
        if (int'(c) == 1) c1_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_busy_cycle", int'(busy), 0);
        end else begin
          mon_r = exp_q.pop_front();
          chk("run_uaddr", int'(uaddr), mon_r.ua);
          chk("run_c", int'(c), mon_r.cw);
          chk("run_err", int'(err), mon_r.e);
          chk("run_done", int'(done), 0);
        end
      end
      if (done && !prev_done) begin
        done_cyc = cyc;
        chk("trace_left", exp_q.size(), 0);
        if (halt_q.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          mon_r = halt_q.pop_front();
          chk("halt_uaddr", int'(uaddr), mon_r.ua);
          chk("halt_err", int'(err), mon_r.e);
          chk("halt_busy", int'(busy), 0);
          chk("halt_c", int'(c), 0);
          last_halt = mon_r.ua;
        end
      end else if (done && prev_done) begin
        chk("hold_uaddr", int'(uaddr), last_halt);
        chk("hold_c", int'(c), 0);
      end
      prev_done = done;
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    start = 1'b0;
    exp_q.delete();
    halt_q.delete();
    m_cnt = 0;
    m_err = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < DEPTH; a++) mem[a] = mk(5, 0, 0, 0);
  endtask

  task automatic set_cond(input int v, input bit rnd);
    for (int s = 0; s < MAXS; s++) cond_seq[s] = rnd ? NCOND'($urandom) : NCOND'(v);
  endtask

  task automatic run_prog(output int lat);
    int len, st;
    bit ok;
    model(1'b1, len, ok);
    c1_cnt = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    st = cyc;
    cond = cond_seq[0];
    start = 1'b0;
    for (int k = 1; k < len; k++) begin
      @(posedge clk); #1;
      cond  = cond_seq[k];
      start = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < 4 && !done; w++) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    if (!done) begin
      chk("done_timeout", int'(done), 1);
      lat = -1;
      apply_reset();
    end else begin
      lat = done_cyc - st;
      if (exp_q.size() != 0 || halt_q.size() != 0) apply_reset();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, len;
    bit ok;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uaddr", int'(uaddr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_c", int'(c), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b1;

    // Asynchronous reset while looping at address 7
    for (int a = 0; a < 7; a++) mem[a] = mk(6, 0, 0, 0);
    mem[7] = mk(0, 7, 7, 'h1234);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    chk("pre_rst_uaddr", int'(uaddr), 7);
    chk("pre_rst_c", int'(c), 'h1234);
    chk("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_uaddr", int'(uaddr), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_c", int'(c), 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_busy", int'(busy), 0);
    chk("idle_uaddr", int'(uaddr), 0);
    chk("idle_done", int'(done), 0);
    m_cnt = 0;
    m_err = 0;
    mon_en = 1'b1;

    // Branch and condition select
    clear_mem();
    mem[0] = mk(0, 2, 9, 'h0011);
    mem[1] = mk(5, 0, 0, 'h0022);
    mem[9] = mk(5, 0, 0, 'h0033);
    set_cond(3'b010, 1'b0);
    run_prog(lat); chk("br_t_lat", lat, 2); chk("br_t_uaddr", int'(uaddr), 9);
    set_cond(3'b000, 1'b0);
    run_prog(lat); chk("br_f_lat", lat, 2); chk("br_f_uaddr", int'(uaddr), 1);
    mem[0] = mk(0, 7, 9, 'h0011);
    set_cond(0, 1'b1);
    run_prog(lat); chk("csel7_uaddr", int'(uaddr), 9);
    mem[0] = mk(0, 5, 9, 'h0011);
    set_cond(3'b111, 1'b0);
    run_prog(lat); chk("csel5_uaddr", int'(uaddr), 1);

    // Hardware loop
    clear_mem();
    mem[0] = mk(1, 0, 3, 0);
    mem[1] = mk(0, 0, 0, 'h0001);
    mem[2] = mk(2, 0, 1, 0);
    mem[3] = mk(5, 0, 0, 0);
    set_cond(0, 1'b1);
    run_prog(lat); chk("loop_lat", lat, 10); chk("loop_c1_cycles", c1_cnt, 4);

    // Subroutine stack
    clear_mem();
    mem[0]  = mk(3, 7, 10, 'h5);
    mem[10] = mk(4, 0, 0, 'h6);
    run_prog(lat);
    chk("call_uaddr", int'(uaddr), 1);
    chk("call_err", int'(err), 0);
`ifdef ROBS_USTACK_EN
    chk("call_lat", lat, 3);
`else
    chk("call_lat", lat, 2);
`endif
    clear_mem();
    for (int a = 2; a < 6; a++) mem[a] = mk(3, 7, a + 1, a);
    mem[0] = mk(3, 7, 2, 0);
    run_prog(lat);
`ifdef ROBS_USTACK_EN
    chk("ovf_uaddr", int'(uaddr), 6); chk("ovf_err", int'(err), 1); chk("ovf_lat", lat, 6);
`else
    chk("ovf_uaddr", int'(uaddr), 1); chk("ovf_err", int'(err), 0); chk("ovf_lat", lat, 2);
`endif
    apply_reset();
    clear_mem();
    mem[0] = mk(4, 0, 0, 0);
    run_prog(lat);
    chk("unf_uaddr", int'(uaddr), 1);
    chk("unf_lat", lat, 2);
`ifdef ROBS_USTACK_EN
    chk("unf_err", int'(err), 1);
`else
    chk("unf_err", int'(err), 0);
`endif

    // Wrap from 31 to 0
    clear_mem();
    mem[0]  = mk(0, 1, 31, 0);
    mem[31] = mk(0, 0, 0, 'h7);
    set_cond(0, 1'b0);
    cond_seq[0] = 3'b001;
    run_prog(lat); chk("wrap_lat", lat, 4); chk("wrap_uaddr", int'(uaddr), 1);

    // Random programs, random conditions, random ignored starts
    for (int t = 0; t < 40; t++) begin
      ok = 1'b0;
      for (int tries = 0; tries < 20 && !ok; tries++) begin
        for (int a = 0; a < DEPTH; a++) begin
          int r, op;
          r = $urandom_range(0, 9);
          op = (r <= 2) ? 0 : (r == 3) ? 1 : (r == 4) ? 2 : (r == 5) ? 3 :
               (r == 6) ? 4 : (r == 7) ? 5 : (r == 8) ? 6 : 7;
          mem[a] = mk(op, $urandom_range(0, 7), $urandom_range(0, 31), $urandom);
        end
        set_cond(0, 1'b1);
        model(1'b0, len, ok);
      end
      if (ok) begin
        run_prog(lat);
        chk("rand_lat", lat, len);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
